// File: rtl/cmd_mode_switch.sv
// cmd_mode_switch: decodes 16-bit host commands into NUM_CH mode bits.
// A command is applied only after CONFIRM_CNT identical consecutive strobes,
// and each real mode change is followed by a HOLDOFF-cycle lockout window.
// Optional: define CMD_WDOG_EN to add an inactivity watchdog that clears all
// mode bits after TIMEOUT cycles without a valid-prefix strobe.
module cmd_mode_switch #(
    parameter int          NUM_CH      = 4,
    parameter int          CONFIRM_CNT = 2,
    parameter int          HOLDOFF     = 24000,
    parameter logic [7:0]  CMD_PREFIX  = 8'hC8,
    parameter logic [3:0]  CH_BASE     = 4'h9,
    parameter int          TIMEOUT     = 24000000
) (
    input  logic              clk_24m,
    input  logic              rst,
    input  logic [15:0]       cmd,
    input  logic              cmd_valid,
    output logic [NUM_CH-1:0] mode,
    output logic [NUM_CH-1:0] mode_chg,
    output logic              cmd_ack,
    output logic              cmd_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        APPLY,
        LOCK
    } state_t;

    localparam int         LOCK_W      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [3:0] CONFIRM_TGT = 4'(CONFIRM_CNT);
    localparam logic [3:0] OP_SET      = 4'h1;
    localparam logic [3:0] OP_CLR      = 4'h4;
    localparam logic [3:0] OP_TGL      = 4'h7;
    localparam logic [3:0] OP_ALL      = 4'hF;

    state_t              state, state_nxt;
    logic [3:0]          confirm_cnt, confirm_cnt_nxt;
    logic [15:0]         held_cmd, held_cmd_nxt;
    logic [LOCK_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic [NUM_CH-1:0]   mode_nxt, mode_chg_nxt, mode_new;
    logic                cmd_ack_nxt, cmd_err_nxt;

    logic [15:0]         cmd_q;
    logic                cmd_valid_q;
    logic                in_prefix_ok, in_legal, cmd_ok, cmd_bad;
    logic [NUM_CH-1:0]   in_mask, held_mask;
    logic                wd_fire;

    // One-hot channel select for a channel field; all zero when the field
    // falls below CH_BASE or beyond the last implemented channel.
    function automatic logic [NUM_CH-1:0] chan_mask(input logic [3:0] sel);
        logic [NUM_CH-1:0] m;
        logic [4:0]        off;
        m   = '0;
        off = {1'b0, sel} - {1'b0, CH_BASE};
        for (int i = 0; i < NUM_CH; i++) begin
            m[i] = !off[4] && (off == 5'(i));
        end
        return m;
    endfunction

    // Register the incoming strobe so decode works from a stable copy.
    always_ff @(posedge clk_24m) begin
        if (rst) begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            cmd_q       <= cmd;
            cmd_valid_q <= cmd_valid;
        end
    end

    assign in_prefix_ok = (cmd_q[15:8] == CMD_PREFIX);
    assign in_mask      = chan_mask(cmd_q[7:4]);
    assign held_mask    = chan_mask(held_cmd[7:4]);

    // Opcode legality: per-channel ops need an existing channel, clear-all
    // must address the base channel code.
    always_comb begin
        in_legal = 1'b0;
        case (cmd_q[3:0])
            OP_SET, OP_CLR, OP_TGL: in_legal = |in_mask;
            OP_ALL:                 in_legal = (cmd_q[7:4] == CH_BASE);
            default:                in_legal = 1'b0;
        endcase
    end

    assign cmd_ok  = cmd_valid_q && in_prefix_ok && in_legal;
    assign cmd_bad = cmd_valid_q && in_prefix_ok && !in_legal;

    // Mode vector that the held command would produce if applied now.
    always_comb begin
        mode_new = mode;
        case (held_cmd[3:0])
            OP_SET:  mode_new = mode | held_mask;
            OP_CLR:  mode_new = mode & ~held_mask;
            OP_TGL:  mode_new = mode ^ held_mask;
            OP_ALL:  mode_new = '0;
            default: mode_new = mode;
        endcase
    end

`ifdef CMD_WDOG_EN
    localparam logic [24:0] WD_LAST = 25'(TIMEOUT - 1);

    logic [24:0] wd_cnt;
    logic        wd_kick;

    assign wd_kick = cmd_valid_q && in_prefix_ok;
    assign wd_fire = !wd_kick && (wd_cnt == WD_LAST);

    // Inactivity counter, restarted by any strobe carrying the right prefix.
    always_ff @(posedge clk_24m) begin
        if (rst || wd_kick || wd_fire) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 25'd1;
        end
    end
`else
    assign wd_fire = 1'b0;

    // TIMEOUT only matters with the watchdog built in; this empty block keeps
    // the parameter referenced so both builds share one parameter list.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // Next-state and next-output logic: confirmation, apply and lockout.
    always_comb begin
        state_nxt       = state;
        confirm_cnt_nxt = confirm_cnt;
        held_cmd_nxt    = held_cmd;
        lock_cnt_nxt    = lock_cnt;
        mode_nxt        = mode;
        mode_chg_nxt    = '0;
        cmd_ack_nxt     = 1'b0;
        cmd_err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_ok) begin
                    held_cmd_nxt    = cmd_q;
                    confirm_cnt_nxt = 4'd1;
                    state_nxt       = (CONFIRM_CNT == 1) ? APPLY : COUNT;
                end else if (cmd_bad) begin
                    cmd_err_nxt     = 1'b1;
                    confirm_cnt_nxt = 4'd0;
                end
            end

            COUNT: begin
                if (cmd_valid_q) begin
                    if (cmd_ok && (cmd_q == held_cmd)) begin
                        confirm_cnt_nxt = confirm_cnt + 4'd1;
                        if ((confirm_cnt + 4'd1) == CONFIRM_TGT) begin
                            state_nxt = APPLY;
                        end
                    end else if (cmd_ok) begin
                        held_cmd_nxt    = cmd_q;
                        confirm_cnt_nxt = 4'd1;
                    end else begin
                        cmd_err_nxt     = cmd_bad;
                        confirm_cnt_nxt = 4'd0;
                        state_nxt       = IDLE;
                    end
                end
            end

            APPLY: begin
                mode_nxt        = mode_new;
                mode_chg_nxt    = mode ^ mode_new;
                cmd_ack_nxt     = 1'b1;
                confirm_cnt_nxt = 4'd0;
                if ((|(mode ^ mode_new)) && (HOLDOFF > 0)) begin
                    state_nxt    = LOCK;
                    lock_cnt_nxt = LOCK_W'(HOLDOFF - 1);
                end else begin
                    state_nxt    = IDLE;
                end
            end

            LOCK: begin
                if (lock_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    lock_cnt_nxt = lock_cnt - 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (wd_fire) begin
            state_nxt       = IDLE;
            confirm_cnt_nxt = 4'd0;
            lock_cnt_nxt    = '0;
            mode_nxt        = '0;
            mode_chg_nxt    = mode;
            cmd_ack_nxt     = 1'b0;
            cmd_err_nxt     = 1'b0;
        end
    end

    // State, counters, held command and registered outputs.
    always_ff @(posedge clk_24m) begin
        if (rst) begin
            state       <= IDLE;
            confirm_cnt <= 4'd0;
            held_cmd    <= '0;
            lock_cnt    <= '0;
            mode        <= '0;
            mode_chg    <= '0;
            cmd_ack     <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            confirm_cnt <= confirm_cnt_nxt;
            held_cmd    <= held_cmd_nxt;
            lock_cnt    <= lock_cnt_nxt;
            mode        <= mode_nxt;
            mode_chg    <= mode_chg_nxt;
            cmd_ack     <= cmd_ack_nxt;
            cmd_err     <= cmd_err_nxt;
        end
    end

    assign busy = (state == LOCK);

endmodule

// File: tb/tb_cmd_mode_switch.sv
// Testbench for cmd_mode_switch: scoreboard of expected output events keyed
// by the cycle they must appear in; any pulse outside an expected event is
// reported. Watchdog scenarios are compiled in when CMD_WDOG_EN is defined.
`timescale 1ns/1ps
module tb_cmd_mode_switch;

    localparam int HOLD_TB = 40;
`ifdef CMD_WDOG_EN
    localparam int TIMEOUT_TB = 100;
`else
    localparam int TIMEOUT_TB = 24000000;
`endif

    typedef struct {
        int         due;
        logic [3:0] mode;
        logic [3:0] chg;
        logic       ack;
        logic       err;
        string      tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cmd = '0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  mode, mode_chg;
    logic        cmd_ack, cmd_err, busy;

    exp_t        sb[$];
    int          cycle = 0;
    int          vectorCount = 0;
    int          missCount = 0;
    bit          started = 1'b0;
    logic [3:0]  expMode = '0;

    cmd_mode_switch #(
        .NUM_CH      (4),
        .CONFIRM_CNT (2),
        .HOLDOFF     (HOLD_TB),
        .CMD_PREFIX  (8'hC8),
        .CH_BASE     (4'h9),
        .TIMEOUT     (TIMEOUT_TB)
    ) dut (
        .clk_24m   (clk),
        .rst       (rst),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .mode      (mode),
        .mode_chg  (mode_chg),
        .cmd_ack   (cmd_ack),
        .cmd_err   (cmd_err),
        .busy      (busy)
    );

    // 24 MHz-ish clock and a free-running edge counter.
    always #21 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL globalTimeout: got cycle %0d, required finish", cycle);
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic expectAt(input int due, input logic [3:0] m, input logic [3:0] chg,
                            input logic ack, input logic err, input string tag);
        exp_t e;
        e.due = due; e.mode = m; e.chg = chg; e.ack = ack; e.err = err; e.tag = tag;
        sb.push_back(e);
    endtask

    // One strobe; edgeNo is the clock edge at which the DUT samples it.
    task automatic applyStimulus(input logic [15:0] w, output int edgeNo);
        @(negedge clk);
        cmd       = w;
        cmd_valid = 1'b1;
        edgeNo    = cycle + 1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = '0;
    endtask

    task automatic waitUntilCycle(input int c);
        while (cycle < c) @(negedge clk);
    endtask

    task automatic waitBusyLow(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Two identical strobes; expects the apply event and, when the mode
    // really changes, a lockout of exactly HOLD_TB cycles.
    task automatic confirmCmd(input logic [15:0] w, input logic [3:0] newMode,
                              input string tag, output int lastEdge);
        int e1, n;
        applyStimulus(w, e1);
        applyStimulus(w, lastEdge);
        expectAt(lastEdge + 2, newMode, expMode ^ newMode, 1'b1, 1'b0, tag);
        waitUntilCycle(lastEdge + 2);
        if (newMode != expMode) begin
            n = 0;
            while (busy === 1'b1 && n < 1000) begin
                n++;
                @(negedge clk);
            end
            checkOutput({tag, ".busyLen"}, 32'(n), 32'(HOLD_TB));
        end else begin
            @(negedge clk);
            checkOutput({tag, ".noLock"}, 32'(busy), 32'd0);
        end
        expMode = newMode;
    endtask

    // Scoreboard monitor: compare due events, flag any unexpected pulse.
    always @(negedge clk) begin
        exp_t e;
        if (started && !rst) begin
            if (sb.size() > 0 && sb[0].due == cycle) begin
                e = sb.pop_front();
                checkOutput({e.tag, ".mode"}, 32'(mode), 32'(e.mode));
                checkOutput({e.tag, ".chg"},  32'(mode_chg), 32'(e.chg));
                checkOutput({e.tag, ".ack"},  32'(cmd_ack), 32'(e.ack));
                checkOutput({e.tag, ".err"},  32'(cmd_err), 32'(e.err));
            end else if (mode_chg != 4'd0 || cmd_ack || cmd_err) begin
                checkOutput("unexpectedPulse", {26'd0, cmd_ack, cmd_err, mode_chg}, 32'd0);
            end
        end
    end

    initial begin
        int e, e1, e2, last;
        logic [15:0] errCmds [5];
        bit          errExp  [5];
        errCmds = '{16'hC8D1, 16'hC8E1, 16'hC8A5, 16'hC8AF, 16'h1234};
        errExp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset.mode", 32'(mode), 32'd0);
        checkOutput("reset.chg",  32'(mode_chg), 32'd0);
        checkOutput("reset.ack",  32'(cmd_ack), 32'd0);
        checkOutput("reset.err",  32'(cmd_err), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        started = 1'b1;

        // Confirmation break: only the repeated clear is applied (redundant).
        applyStimulus(16'hC891, e);
        applyStimulus(16'hC894, e);
        applyStimulus(16'hC894, e);
        expectAt(e + 2, 4'b0000, 4'b0000, 1'b1, 1'b0, "breakRedundant");
        waitUntilCycle(e + 3);
        checkOutput("breakRedundant.noLock", 32'(busy), 32'd0);

        // Set channel 0, then channel 2.
        confirmCmd(16'hC891, 4'b0001, "setCh0", last);
        confirmCmd(16'hC8B1, 4'b0101, "setCh2", last);

        // Toggle channel 2, then try a command while locked.
        applyStimulus(16'hC8B7, e1);
        applyStimulus(16'hC8B7, e2);
        expectAt(e2 + 2, 4'b0001, 4'b0100, 1'b1, 1'b0, "toggleCh2");
        waitUntilCycle(e2 + 2);
        checkOutput("toggleCh2.busy", 32'(busy), 32'd1);
        expMode = 4'b0001;
        applyStimulus(16'hC8A1, e);
        applyStimulus(16'hC8A1, e);
        waitBusyLow("lockIgnore.lockEnd");
        repeat (4) @(negedge clk);
        checkOutput("lockIgnore.mode", 32'(mode), 32'(expMode));

        // Malformed and foreign commands.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(errCmds[i], e);
            if (errExp[i]) expectAt(e + 1, expMode, 4'b0000, 1'b0, 1'b1, $sformatf("err%0h", errCmds[i]));
        end
        repeat (4) @(negedge clk);

        // Set channel 3, then clear-all reports every previously set bit.
        confirmCmd(16'hC8C1, 4'b1001, "setCh3", last);
        confirmCmd(16'hC89F, 4'b0000, "clearAll", last);

        // Reset between two strobes must abort the confirmation.
        applyStimulus(16'hC891, e);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(16'hC891, e);
        waitUntilCycle(e + 6);
        checkOutput("resetAbort.mode", 32'(mode), 32'd0);
        pulseReset();

`ifdef CMD_WDOG_EN
        // Inactivity clears the mode without an acknowledge.
        confirmCmd(16'hC891, 4'b0001, "wdSet0", last);
        confirmCmd(16'hC8A1, 4'b0011, "wdSet1", last);
        expectAt(last + TIMEOUT_TB + 1, 4'b0000, 4'b0011, 1'b0, 1'b0, "wdogClear");
        expMode = 4'b0000;
        waitUntilCycle(last + TIMEOUT_TB + 3);

        // A prefixed strobe midway restarts the inactivity window.
        confirmCmd(16'hC891, 4'b0001, "wdSet0b", last);
        confirmCmd(16'hC8A1, 4'b0011, "wdSet1b", last);
        waitUntilCycle(last + 50);
        applyStimulus(16'hC8A1, e);
        expectAt(e + TIMEOUT_TB + 1, 4'b0000, 4'b0011, 1'b0, 1'b0, "wdogDelayed");
        expMode = 4'b0000;
        waitUntilCycle(e + TIMEOUT_TB + 3);
`endif

        repeat (5) @(negedge clk);
        checkOutput("scoreboardDrain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/cmd_mode_switch.md
Name: cmd_mode_switch

Overview:
- Parametrised successor to the single-bit speed switch.
- Decodes 16-bit commands from the host link into NUM_CH independent mode bits, each with set, clear and toggle opcodes, plus a clear-all opcode.
- A command acts only after CONFIRM_CNT consecutive identical valid strobes, which gives noise immunity.
- After any mode change, a lockout window blocks further changes.
- Sits between the command deserialiser and the datapath mode controls.

Parameters:
- NUM_CH, 4, number of mode channels, legal range 1..7.
- CONFIRM_CNT, 2, consecutive identical strobes required before acting, legal range 1..15.
- HOLDOFF, 24000, lockout cycles after a mode change (1 ms at 24 MHz); 0 disables lockout.
- CMD_PREFIX, 8'hC8, required value of cmd[15:8].
- CH_BASE, 4'h9, value of cmd[7:4] that selects channel 0.
- TIMEOUT, 24000000, watchdog cycles; used only when CMD_WDOG_EN is defined.

Ports:
- clk_24m  in  1  system clock, 24 MHz.
- rst  in  1  synchronous reset, active-high.
- cmd  in  16  command word, sampled only when cmd_valid=1.
- cmd_valid  in  1  one-cycle strobe qualifying cmd.
- mode  out  NUM_CH  registered mode bits, one per channel.
- mode_chg  out  NUM_CH  one-cycle pulse on each channel whose mode bit changed.
- cmd_ack  out  1  one-cycle pulse when a confirmed command is applied.
- cmd_err  out  1  one-cycle pulse on a malformed command.
- busy  out  1  high while in LOCK.

Behaviour:
- Clocking: single clock. rst is synchronous and active-high.
- Reset state: mode=0, mode_chg=0, cmd_ack=0, cmd_err=0, busy=0, state=IDLE, confirm counter=0, held command register=0.
- rst asserted mid-operation aborts any confirmation or lockout on the next edge.
- Decode, evaluated on a strobe:
  - Valid command requires cmd[15:8]==CMD_PREFIX.
  - Channel ch = cmd[7:4]-CH_BASE, with 0<=ch<NUM_CH.
  - Opcode cmd[3:0]: 4'h1 set, 4'h4 clear, 4'h7 toggle, 4'hF clear-all. For clear-all, cmd[7:4] must equal CH_BASE.
  - With the default parameters, channel 0 codes are C891 (set) and C894 (clear).
- Malformed strobes:
  - Prefix mismatch: ignored silently.
  - Prefix matches but channel or opcode is illegal: cmd_err pulses 1 cycle after the strobe, and the confirm counter clears.
- State machine:
  - IDLE: a valid strobe loads the held command and sets cnt=1. If CONFIRM_CNT==1, go to APPLY; otherwise go to COUNT.
  - COUNT, on each strobe:
    - cmd equals the held command: cnt++. When cnt reaches CONFIRM_CNT, go to APPLY.
    - cmd is a different valid command: reload the held command, set cnt=1, stay in COUNT.
    - cmd is invalid: go to IDLE.
  - COUNT with no strobe: holds, with no inter-strobe timeout.
  - APPLY (exactly 1 cycle):
    - Update mode and pulse cmd_ack.
    - Set mode_chg bits for the channels whose value actually changed.
    - If any bit changed and HOLDOFF>0, go to LOCK. Otherwise go to IDLE.
  - LOCK:
    - busy=1; a down-counter loads HOLDOFF-1 on entry.
    - All strobes are ignored: no cmd_err, no counting.
    - When the counter reaches 0, go to IDLE.
- Latency:
  - mode and the mode_chg/cmd_ack pulses appear 2 cycles after the confirming strobe edge.
  - Strobe at edge N → APPLY at N+1 → outputs registered visible from N+2.
- Redundant command (set on a bit already 1, clear on 0): cmd_ack pulses, mode_chg stays 0, no LOCK.
- Strobe during APPLY: ignored.
- mode_chg and cmd_ack are never asserted in the same cycle as cmd_err.

Optional Feature:
- Macro: CMD_WDOG_EN.
- Defined:
  - A 25-bit counter counts cycles since the last valid-prefix strobe and clears on every such strobe.
  - On reaching TIMEOUT-1, mode is forced to 0 next cycle, mode_chg pulses for the bits that were 1, and state goes to IDLE. This overrides LOCK.
  - cmd_ack does not pulse on a watchdog clear.
- Not defined: no counter logic; mode holds indefinitely.

Test Plan:
- Reset/default: rst high 3 cycles → mode=0, busy=0, all pulses 0. Then two strobes of C891 → mode[0]=1, mode_chg=4'b0001, cmd_ack=1, both 2 cycles after the 2nd strobe; busy=1 for 24000 cycles.
- Confirmation break: C891, C894, C894 → only the clear is applied. mode[0] unchanged from 0, cmd_ack=1, mode_chg=0, no LOCK.
- Multi-channel and toggle (HOLDOFF=4):
  - C8B1 ×2 → mode=4'b0100.
  - Wait 4 cycles, then C8B7 ×2 → mode=4'b0000 with mode_chg=4'b0100.
- Errors:
  - C8D1 with NUM_CH=4 (ch=4) → cmd_err pulse, mode unchanged.
  - C8E1 → cmd_err.
  - C8A5 → cmd_err.
  - 1234 → no response.
- Lockout and clear-all:
  - During LOCK, send C8A1 ×2 → ignored.
  - After busy falls, C89F ×2 → all bits cleared; mode_chg equals the previous mode.
- Watchdog (CMD_WDOG_EN, TIMEOUT=100):
  - Set mode=4'b0011, then idle 100 cycles → mode=0, mode_chg=4'b0011, cmd_ack=0.
  - Rerun with a C8xx strobe at cycle 50 → no clear before cycle 150.
